// File: rtl/clk_seq_pkg.sv
// Shared state encoding and default timing constants for the clock sequencer.
package clk_seq_pkg;

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] RECONF    = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    typedef enum logic [2:0] {
        StPllRst   = PLL_RST,
        StWaitLock = WAIT_LOCK,
        StRun      = RUN,
        StReconf   = RECONF,
        StFault    = FAULT
    } state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 1024;
    localparam int unsigned DEF_DEFAULT_DIV    = 52;

endpackage

// File: rtl/clk_seq_divider.sv
// Half-period divider: counts 0..active_div-1, toggles clk_out and pulses tick at each wrap.
// A pending ratio is taken only at a wrap, so no half-period is ever truncated.
module clk_seq_divider
    import clk_seq_pkg::*;
#(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             flush,
    input  logic             load,
    input  logic [NBITS-1:0] load_value,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] active_div_q, active_div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q;

    assign wrap = en && (cnt_q == active_div_q - NBITS'(1));

    always_comb begin
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        active_div_d = active_div_q;
        if (en) begin
            cnt_d = cnt_q + NBITS'(1);
        end
        if (wrap) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            if (load) begin
                active_div_d = load_value;
            end
        end
        // Clear still lets a coincident wrap toggle clk_out.
        if (clr) begin
            cnt_d = '0;
        end
        if (flush) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            active_div_q <= NBITS'(DEFAULT_DIV);
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= wrap;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_seq_ctrl.sv
// PLL reset/lock sequencer with run-time divide-ratio handshake.
// Define CLK_SEQ_LOCK_CNT_EN to add the saturating lock_loss_cnt output.
module clk_seq_ctrl
    import clk_seq_pkg::*;
#(
    parameter int unsigned NBITS          = 32,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned DEFAULT_DIV    = DEF_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    output logic             pll_areset,
    input  logic             div_req,
    input  logic [NBITS-1:0] div_value,
    output logic             div_ack,
    output logic             div_nack,
    output logic             clk_out,
    output logic             tick,
    output logic             ready,
    output logic             error
`ifdef CLK_SEQ_LOCK_CNT_EN
    ,
    output logic [7:0]       lock_loss_cnt
`endif
);

    localparam int unsigned CNT_MAX = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [NBITS-1:0] pending_q, pending_d;
    logic             ack_d, nack_d;
    logic             ack_q, nack_q, pll_areset_q, ready_q, error_q;
    logic             div_en, div_clr, div_flush, div_load, div_wrap;
    logic             lock_lost;

    assign lock_lost = ((state_q == StRun) || (state_q == StReconf)) && !pll_locked;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        div_en    = 1'b0;
        div_clr   = 1'b0;
        div_load  = 1'b0;
        unique case (state_q)
            StPllRst: begin
                if (seq_cnt_q == RST_LAST) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (pll_locked)                state_d = StRun;
                else if (seq_cnt_q == TO_LAST) state_d = StFault;
            end
            StRun: begin
                div_en = 1'b1;
                if (lock_lost) begin
                    state_d = StWaitLock;
                    div_clr = 1'b1;
                end else if (div_req) begin
                    if (div_value == '0) begin
                        nack_d = 1'b1;
                    end else begin
                        pending_d = div_value;
                        state_d   = StReconf;
                    end
                end
            end
            StReconf: begin
                div_en = 1'b1;
                if (lock_lost) begin
                    state_d = StWaitLock;
                    div_clr = 1'b1;
                    nack_d  = 1'b1;
                end else begin
                    div_load = 1'b1;
                    if (div_wrap) begin
                        ack_d   = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StFault: ;
            default: state_d = StPllRst;
        endcase

        // One counter serves both the reset hold and the lock timeout.
        if ((state_d == state_q) && ((state_q == StPllRst) || (state_q == StWaitLock))) begin
            seq_cnt_d = seq_cnt_q + CNT_W'(1);
        end else begin
            seq_cnt_d = '0;
        end
        div_flush = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StPllRst;
            seq_cnt_q    <= '0;
            pending_q    <= '0;
            ack_q        <= 1'b0;
            nack_q       <= 1'b0;
            pll_areset_q <= 1'b1;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            pll_areset_q <= (state_d == StPllRst) || (state_d == StFault);
            ready_q      <= (state_d == StRun) || (state_d == StReconf);
            error_q      <= (state_d == StFault);
        end
    end

    clk_seq_divider #(
        .NBITS      (NBITS),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .en        (div_en),
        .clr       (div_clr),
        .flush     (div_flush),
        .load      (div_load),
        .load_value(pending_q),
        .wrap      (div_wrap),
        .clk_out   (clk_out),
        .tick      (tick)
    );

`ifdef CLK_SEQ_LOCK_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            loss_cnt_q <= '0;
        end else if (lock_lost && (loss_cnt_q != 8'hff)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

    assign pll_areset = pll_areset_q;
    assign div_ack    = ack_q;
    assign div_nack   = nack_q;
    assign ready      = ready_q;
    assign error      = error_q;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Directed bench for clk_seq_ctrl: power-up, reject, lock loss, reset abort, reconfig, timeout.
module tb_clk_seq_ctrl;

    localparam int unsigned NBITS = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pll_locked = 1'b0;
    logic             div_req = 1'b0;
    logic [NBITS-1:0] div_value = '0;
    logic             pll_areset, div_ack, div_nack, clk_out, tick, ready, error;
`ifdef CLK_SEQ_LOCK_CNT_EN
    logic [7:0]       lock_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_seq_ctrl #(
        .NBITS         (NBITS),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (16),
        .DEFAULT_DIV   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .pll_areset(pll_areset),
        .div_req   (div_req),
        .div_value (div_value),
        .div_ack   (div_ack),
        .div_nack  (div_nack),
        .clk_out   (clk_out),
        .tick      (tick),
        .ready     (ready),
        .error     (error)
`ifdef CLK_SEQ_LOCK_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pll_areset, clk_out, tick, ready, error, div_ack, div_nack} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1000000",
                     {pll_areset, clk_out, tick, ready, error, div_ack, div_nack});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_power_up();
        int n;
        n = 0;
        while (pll_areset === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL areset_len: got %0d expected 4", n); end
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_pre_lock: got %b expected 0", ready); end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_on_lock: got %b expected 1", ready); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3 || clk_out !== 1'b1) begin
            errors++; $display("FAIL first_rise: got %0d/%b expected 3/1", n, clk_out);
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL tick_pulse: got %b expected 0", tick); end
        n = 1;
        do begin @(negedge clk); n++; end while (!(tick === 1'b1 && clk_out === 1'b1) && n < 20);
        checks++;
        if (n != 6) begin errors++; $display("FAIL period: got %0d expected 6", n); end
    endtask

    task automatic test_reject();
        int n;
        bit ack_seen;
        ack_seen = 1'b0;
        div_req = 1'b1;
        div_value = '0;
        @(negedge clk);
        checks++;
        if (div_nack !== 1'b1 || div_ack !== 1'b0) begin
            errors++; $display("FAIL reject_nack: got nack=%b ack=%b expected 1/0", div_nack, div_ack);
        end
        div_req = 1'b0;
        @(negedge clk);
        checks++;
        if (div_nack !== 1'b0) begin errors++; $display("FAIL nack_pulse: got %b expected 0", div_nack); end
        n = 2;
        do begin @(negedge clk); n++; ack_seen |= div_ack; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3) begin errors++; $display("FAIL reject_half1: got %0d expected 3", n); end
        n = 0;
        do begin @(negedge clk); n++; ack_seen |= div_ack; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3 || ack_seen) begin
            errors++; $display("FAIL reject_half2: got %0d ack=%b expected 3 ack=0", n, ack_seen);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        logic v;
        bit tick_seen;
        tick_seen = 1'b0;
        v = clk_out;
        div_req = 1'b1;
        div_value = 8'd7;
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        checks++;
        if ({div_nack, div_ack, ready, clk_out} !== {3'b100, v}) begin
            errors++; $display("FAIL loss_nack: got %b expected %b",
                               {div_nack, div_ack, ready, clk_out}, {3'b100, v});
        end
        div_req = 1'b0;
        repeat (3) begin @(negedge clk); tick_seen |= tick; end
        checks++;
        if (clk_out !== v || tick_seen || div_nack !== 1'b0) begin
            errors++; $display("FAIL loss_frozen: got clk_out=%b tick=%b nack=%b expected %b/0/0",
                               clk_out, tick_seen, div_nack, v);
        end
        pll_locked = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL relock_ready: got %b expected 1", ready); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3 || clk_out !== ~v) begin
            errors++; $display("FAIL relock_first: got %0d/%b expected 3/%b", n, clk_out, ~v);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3) begin errors++; $display("FAIL relock_ratio: got %0d expected 3", n); end
`ifdef CLK_SEQ_LOCK_CNT_EN
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            errors++; $display("FAIL lock_loss_cnt: got %0d expected 1", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(tick === 1'b1 && clk_out === 1'b1) && n < 40);
        @(negedge clk);
        div_req = 1'b1;
        div_value = 8'd5;
        @(negedge clk);
        checks++;
        if (clk_out !== 1'b1 || n >= 40) begin
            errors++; $display("FAIL mid_run_setup: got clk_out=%b wait=%0d expected 1", clk_out, n);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pll_areset, clk_out, tick, ready, error, div_ack, div_nack} !== 7'b1000000) begin
            errors++; $display("FAIL mid_run_reset: got %b expected 1000000",
                               {pll_areset, clk_out, tick, ready, error, div_ack, div_nack});
        end
        reset = 1'b1;
        div_req = 1'b0;
        @(negedge clk);
        checks++;
        if (div_ack !== 1'b0 || div_nack !== 1'b0 || pll_areset !== 1'b1) begin
            errors++; $display("FAIL mid_run_after: got ack=%b nack=%b areset=%b expected 0/0/1",
                               div_ack, div_nack, pll_areset);
        end
    endtask

    task automatic test_reconfig();
        int n;
        bit nack_seen;
        nack_seen = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL bring_up: got %b expected 1", ready); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 40);
        @(negedge clk);
        div_req = 1'b1;
        div_value = 8'd5;
        n = 0;
        do begin @(negedge clk); n++; nack_seen |= div_nack; end while (div_ack !== 1'b1 && n < 10);
        checks++;
        if (n != 2 || tick !== 1'b1) begin
            errors++; $display("FAIL reconf_ack: got %0d tick=%b expected 2 tick=1", n, tick);
        end
        div_req = 1'b0;
        @(negedge clk);
        checks++;
        if (div_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b expected 0", div_ack); end
        n = 1;
        do begin @(negedge clk); n++; nack_seen |= div_nack; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 5) begin errors++; $display("FAIL reconf_half1: got %0d expected 5", n); end
        n = 0;
        do begin @(negedge clk); n++; nack_seen |= div_nack; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 5 || nack_seen) begin
            errors++; $display("FAIL reconf_half2: got %0d nack=%b expected 5 nack=0", n, nack_seen);
        end
    endtask

    task automatic test_timeout();
        int n;
        pll_locked = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                checks++;
                if (pll_areset !== 1'b0) begin
                    errors++; $display("FAIL wait_areset: got %b expected 0", pll_areset);
                end
            end
        end
        checks++;
        if (n != 20 || pll_areset !== 1'b1 || ready !== 1'b0 || clk_out !== 1'b0) begin
            errors++; $display("FAIL timeout: got n=%0d areset=%b ready=%b clk_out=%b expected 20/1/0/0",
                               n, pll_areset, ready, clk_out);
        end
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL fault_sticky: got error=%b ready=%b expected 1/0", error, ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", error); end
        reset = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (ready !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL restart: got ready=%b error=%b expected 1/0", ready, error);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_reject();
        test_lock_loss();
        test_reset_mid_run();
        test_reconfig();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
